md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
- Multi-cycle multiply/divide unit with architectural HI/LO registers for the single-cycle MIPS datapath.
- Consumes the two register-file read ports (rs, rt values) and runs mult/multu/div/divu over a fixed number of cycles.
- Its HI/LO values feed the write-back mux for mfhi/mflo, which then writes the register file.
- The controller stalls the PC while busy is high.

Parameters:
- MULT_CYCLES, 5, cycles busy stays high for mult/multu (>=1).
- DIV_CYCLES, 10, cycles busy stays high for div/divu (>=1).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; clears all state.
- start  input  1  request strobe for the operation on op; sampled on a rising edge.
- op  input  3  operation select: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6-7 reserved (no-op).
- rs_val  input  32  first operand (register-file read port 1).
- rt_val  input  32  second operand (register-file read port 2).
- busy  output  1  high while an arithmetic operation is in flight (registered).
- hi  output  32  HI register (registered).
- lo  output  32  LO register (registered).

Behaviour:
- Reset: clk and reset are as stated above (reset synchronous, active-high; clock clk). On a reset edge: hi=0, lo=0, busy=0, internal counter=0, latched operands=0. Reset wins over every other event, including an operation in flight; a pending result is discarded.
- States: IDLE (busy=0) and RUN (busy=1), encoded by busy plus a down-counter of width clog2(max(MULT_CYCLES,DIV_CYCLES))+1.
- Accept, IDLE with start=1 and op in 0..3:
  - latch rs_val, rt_val and op;
  - counter<=MULT_CYCLES for op 0/1, DIV_CYCLES for op 2/3;
  - busy<=1.
- mthi/mtlo, IDLE with start=1 and op 4/5: hi<=rs_val (op 4) or lo<=rs_val (op 5) at that edge; busy stays 0; zero extra latency.
- Reserved op 6/7 with start=1: no state change.
- RUN, each edge:
  - counter>1: counter<=counter-1.
  - counter==1: commit result to hi/lo, busy<=0, counter<=0.
- Timing: busy is high for exactly LAT consecutive cycles after the accept edge. New hi/lo are visible in the first cycle busy=0. hi/lo hold their old values throughout RUN.
- start while busy=1 (any op, including mthi/mtlo) is ignored. The controller guarantees it holds the instruction stalled and re-presents it. No queueing.
- Result computation uses the latched operands only; rs_val/rt_val may change freely during RUN.
- mult: signed 32x32 -> 64; hi=product[63:32], lo=product[31:0].
- multu: as mult, but unsigned.
- div: signed, quotient truncated toward zero; lo=quotient, hi=remainder with sign of dividend. 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- divu: unsigned; lo=quotient, hi=remainder.
- Divide by zero (latched rt==0, div or divu): full busy duration still elapses; hi and lo are left unchanged at commit.
- start asserted in the same cycle busy falls: busy is already 0, so start is accepted at that edge, after the commit. The new op uses the then-current rs_val/rt_val.
- Implementation may compute the result combinationally or iteratively, provided the cycle-level busy/hi/lo behaviour above is exact.

Test Plan:
- Reset then idle: after reset, hi=0, lo=0, busy=0; start=0 for 3 cycles -> all outputs unchanged.
- mult, signed: rs=0xFFFFFFFE (-2), rt=3, op=0, start pulsed 1 cycle:
  - busy high exactly 5 cycles, hi/lo unchanged meanwhile;
  - then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
  - Same operands with op=1 (multu) -> hi=0x00000002, lo=0xFFFFFFFA.
- div, signed: rs=-7 (0xFFFFFFF9), rt=2, op=2:
  - busy high 10 cycles;
  - then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - Same with op=3 (divu) -> lo=0x7FFFFFFC, hi=0x00000001.
- Divide by zero and overflow:
  - mthi 0x1234 then mtlo 0x5678 (each takes effect next edge, busy stays 0);
  - divu by rt=0 -> busy 10 cycles, then hi=0x1234, lo=0x5678;
  - div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Ignored start: during a mult (busy=1), pulse start with op=4, rs=0xDEAD -> hi ends as the mult result, not 0xDEAD; busy length unchanged at 5.
- Reset mid-operation: start div, assert reset on its 4th busy cycle -> next edge busy=0, hi=0, lo=0; no later commit. A new mult accepted after reset completes normally.

Source files
------------

// File: rtl/md_unit_if.sv
// ============================================================================
// Module      : md_unit_if
// Description : Request/result bundle between the MIPS controller/datapath
//               and the multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface md_unit_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, rs_val, rt_val,
        input  busy, hi, lo
    );

    modport slave (
        input  start, op, rs_val, rt_val,
        output busy, hi, lo
    );
endinterface

`default_nettype wire

// File: rtl/md_unit.sv
// ============================================================================
// Module      : md_unit
// Description : Multi-cycle mult/multu/div/divu unit holding the HI/LO
//               architectural registers; busy stalls the PC while in flight.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  wire logic    clk,
    input  wire logic    reset,
    md_unit_if.slave     bus
);

    localparam int        c_MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int        c_CW         = $clog2(c_MAX_CYCLES) + 1;
    localparam logic [c_CW-1:0] c_MULT_LOAD = c_CW'(MULT_CYCLES);
    localparam logic [c_CW-1:0] c_DIV_LOAD  = c_CW'(DIV_CYCLES);

    localparam logic [2:0] c_OP_MULT  = 3'd0;
    localparam logic [2:0] c_OP_MULTU = 3'd1;
    localparam logic [2:0] c_OP_DIV   = 3'd2;
    localparam logic [2:0] c_OP_MTHI  = 3'd4;
    localparam logic [2:0] c_OP_MTLO  = 3'd5;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t          r_state, w_state_next;
    logic [c_CW-1:0] r_count, w_count_next;
    logic [31:0]     r_a, w_a_next;
    logic [31:0]     r_b, w_b_next;
    logic [2:0]      r_op, w_op_next;
    logic [31:0]     r_hi, w_hi_next;
    logic [31:0]     r_lo, w_lo_next;

    // Result datapath works purely from the latched operands.
    logic [63:0] w_prod_s, w_prod_u;
    logic        w_is_signed_div;
    logic [31:0] w_a_mag, w_b_mag, w_b_safe;
    logic [31:0] w_q_mag, w_r_mag, w_quot, w_rem;
    logic [63:0] w_result;

    assign w_prod_s = {{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b};
    assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};

    // Sign-magnitude division sidesteps the 0x80000000 / -1 overflow case:
    // its magnitude quotient 0x80000000 is already the required bit pattern.
    assign w_is_signed_div = (r_op == c_OP_DIV);
    assign w_a_mag  = (w_is_signed_div && r_a[31]) ? (32'd0 - r_a) : r_a;
    assign w_b_mag  = (w_is_signed_div && r_b[31]) ? (32'd0 - r_b) : r_b;
    assign w_b_safe = (w_b_mag == 32'd0) ? 32'd1 : w_b_mag;
    assign w_q_mag  = w_a_mag / w_b_safe;
    assign w_r_mag  = w_a_mag % w_b_safe;
    assign w_quot   = (w_is_signed_div && (r_a[31] ^ r_b[31])) ? (32'd0 - w_q_mag) : w_q_mag;
    assign w_rem    = (w_is_signed_div && r_a[31]) ? (32'd0 - w_r_mag) : w_r_mag;

    always_comb begin
        w_result = 64'd0;
        case (r_op)
            c_OP_MULT:  w_result = w_prod_s;
            c_OP_MULTU: w_result = w_prod_u;
            default:    w_result = {w_rem, w_quot};
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        w_a_next     = r_a;
        w_b_next     = r_b;
        w_op_next    = r_op;
        w_hi_next    = r_hi;
        w_lo_next    = r_lo;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.op[2] == 1'b0) begin
                        w_a_next     = bus.rs_val;
                        w_b_next     = bus.rt_val;
                        w_op_next    = bus.op;
                        w_count_next = bus.op[1] ? c_DIV_LOAD : c_MULT_LOAD;
                        w_state_next = S_RUN;
                    end else if (bus.op == c_OP_MTHI) begin
                        w_hi_next = bus.rs_val;
                    end else if (bus.op == c_OP_MTLO) begin
                        w_lo_next = bus.rs_val;
                    end
                end
            end
            S_RUN: begin
                if (r_count > c_CW'(1)) begin
                    w_count_next = r_count - c_CW'(1);
                end else begin
                    // A zero divisor burns the full latency but leaves HI/LO untouched.
                    if (!(r_op[1] && (r_b == 32'd0))) begin
                        w_hi_next = w_result[63:32];
                        w_lo_next = w_result[31:0];
                    end
                    w_count_next = '0;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_op    <= 3'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            r_a     <= w_a_next;
            r_b     <= w_b_next;
            r_op    <= w_op_next;
            r_hi    <= w_hi_next;
            r_lo    <= w_lo_next;
        end
    end

    assign bus.busy = (r_state == S_RUN);
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_md_unit.sv
// ============================================================================
// Module      : tb_md_unit
// Description : Directed self-checking bench for md_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_md_unit;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    md_unit_if bus ();

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present an op for one edge, then count busy cycles and note whether
    // HI/LO ever moved while busy was high.
    task automatic run_op(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                          output int cycles, output bit held);
        logic [31:0] ph, pl;
        ph = bus.hi;
        pl = bus.lo;
        bus.start  = 1'b1;
        bus.op     = op;
        bus.rs_val = rs;
        bus.rt_val = rt;
        step();
        bus.start = 1'b0;
        cycles = 0;
        held   = 1'b1;
        while (bus.busy === 1'b1 && cycles < 100) begin
            if (bus.hi !== ph || bus.lo !== pl) held = 1'b0;
            cycles++;
            bus.rs_val = $urandom;
            bus.rt_val = $urandom;
            step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        total++;
        if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
            bad++;
            $display("FAIL reset_state busy=%b hi=%h lo=%h expected 0/0/0", bus.busy, bus.hi, bus.lo);
        end
        for (int i = 0; i < 3; i++) step();
        total++;
        if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
            bad++;
            $display("FAIL idle_hold busy=%b hi=%h lo=%h expected 0/0/0", bus.busy, bus.hi, bus.lo);
        end
    endtask

    task automatic test_mult();
        int cyc;
        bit held;
        run_op(3'd0, 32'hFFFFFFFE, 32'd3, cyc, held);
        total++;
        if (cyc !== 5 || held !== 1'b1) begin
            bad++;
            $display("FAIL mult_timing cycles=%0d held=%0d expected 5/1", cyc, held);
        end
        total++;
        if (bus.hi !== 32'hFFFFFFFF || bus.lo !== 32'hFFFFFFFA) begin
            bad++;
            $display("FAIL mult_result hi=%h lo=%h expected ffffffff/fffffffa", bus.hi, bus.lo);
        end
        run_op(3'd1, 32'hFFFFFFFE, 32'd3, cyc, held);
        total++;
        if (cyc !== 5 || bus.hi !== 32'h00000002 || bus.lo !== 32'hFFFFFFFA) begin
            bad++;
            $display("FAIL multu_result cycles=%0d hi=%h lo=%h expected 5/00000002/fffffffa", cyc, bus.hi, bus.lo);
        end
    endtask

    task automatic test_div();
        int cyc;
        bit held;
        run_op(3'd2, 32'hFFFFFFF9, 32'd2, cyc, held);
        total++;
        if (cyc !== 10 || held !== 1'b1) begin
            bad++;
            $display("FAIL div_timing cycles=%0d held=%0d expected 10/1", cyc, held);
        end
        total++;
        if (bus.lo !== 32'hFFFFFFFD || bus.hi !== 32'hFFFFFFFF) begin
            bad++;
            $display("FAIL div_result hi=%h lo=%h expected ffffffff/fffffffd", bus.hi, bus.lo);
        end
        run_op(3'd3, 32'hFFFFFFF9, 32'd2, cyc, held);
        total++;
        if (cyc !== 10 || bus.lo !== 32'h7FFFFFFC || bus.hi !== 32'h00000001) begin
            bad++;
            $display("FAIL divu_result cycles=%0d hi=%h lo=%h expected 10/00000001/7ffffffc", cyc, bus.hi, bus.lo);
        end
    endtask

    task automatic test_div_edge();
        int cyc;
        bit held;
        bus.start  = 1'b1;
        bus.op     = 3'd4;
        bus.rs_val = 32'h1234;
        step();
        total++;
        if (bus.hi !== 32'h1234 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL mthi hi=%h busy=%b expected 00001234/0", bus.hi, bus.busy);
        end
        bus.op     = 3'd5;
        bus.rs_val = 32'h5678;
        step();
        bus.start = 1'b0;
        total++;
        if (bus.lo !== 32'h5678 || bus.hi !== 32'h1234 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL mtlo hi=%h lo=%h busy=%b expected 00001234/00005678/0", bus.hi, bus.lo, bus.busy);
        end
        bus.start = 1'b1;
        bus.op    = 3'd6;
        bus.rs_val = 32'hAAAA;
        step();
        bus.start = 1'b0;
        total++;
        if (bus.hi !== 32'h1234 || bus.lo !== 32'h5678 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL reserved_op hi=%h lo=%h busy=%b expected 00001234/00005678/0", bus.hi, bus.lo, bus.busy);
        end
        run_op(3'd3, 32'd99, 32'd0, cyc, held);
        total++;
        if (cyc !== 10 || bus.hi !== 32'h1234 || bus.lo !== 32'h5678) begin
            bad++;
            $display("FAIL div_by_zero cycles=%0d hi=%h lo=%h expected 10/00001234/00005678", cyc, bus.hi, bus.lo);
        end
        run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, cyc, held);
        total++;
        if (cyc !== 10 || bus.lo !== 32'h80000000 || bus.hi !== 32'd0) begin
            bad++;
            $display("FAIL div_overflow cycles=%0d hi=%h lo=%h expected 10/00000000/80000000", cyc, bus.hi, bus.lo);
        end
    endtask

    task automatic test_ignored_start();
        int cyc;
        bus.start  = 1'b1;
        bus.op     = 3'd0;
        bus.rs_val = 32'hFFFFFFFE;
        bus.rt_val = 32'd3;
        step();
        bus.op     = 3'd4;
        bus.rs_val = 32'hDEAD;
        cyc = 0;
        while (bus.busy === 1'b1 && cyc < 100) begin
            cyc++;
            step();
            bus.start = 1'b0;
        end
        total++;
        if (cyc !== 5 || bus.hi !== 32'hFFFFFFFF || bus.lo !== 32'hFFFFFFFA) begin
            bad++;
            $display("FAIL ignored_start cycles=%0d hi=%h lo=%h expected 5/ffffffff/fffffffa", cyc, bus.hi, bus.lo);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        bit held;
        bit stray;
        bus.start  = 1'b1;
        bus.op     = 3'd2;
        bus.rs_val = 32'd100;
        bus.rt_val = 32'd7;
        step();
        bus.start = 1'b0;
        step();
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        total++;
        if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
            bad++;
            $display("FAIL reset_mid busy=%b hi=%h lo=%h expected 0/0/0", bus.busy, bus.hi, bus.lo);
        end
        stray = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) stray = 1'b1;
        end
        total++;
        if (stray !== 1'b0) begin
            bad++;
            $display("FAIL no_late_commit stray=%0d expected 0", stray);
        end
        run_op(3'd0, 32'd6, 32'd7, cyc, held);
        total++;
        if (cyc !== 5 || bus.hi !== 32'd0 || bus.lo !== 32'd42) begin
            bad++;
            $display("FAIL mult_after_reset cycles=%0d hi=%h lo=%h expected 5/00000000/0000002a", cyc, bus.hi, bus.lo);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        bus.start  = 1'b1;
        bus.op     = 3'd0;
        bus.rs_val = 32'd5;
        bus.rt_val = 32'd6;
        step();
        bus.rs_val = 32'd3;
        bus.rt_val = 32'd4;
        cyc = 0;
        while (bus.busy === 1'b1 && cyc < 100) begin
            cyc++;
            step();
        end
        total++;
        if (cyc !== 5 || bus.lo !== 32'd30 || bus.hi !== 32'd0) begin
            bad++;
            $display("FAIL b2b_first cycles=%0d hi=%h lo=%h expected 5/00000000/0000001e", cyc, bus.hi, bus.lo);
        end
        step();
        bus.start = 1'b0;
        total++;
        if (bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL b2b_accept busy=%b expected 1", bus.busy);
        end
        cyc = 0;
        while (bus.busy === 1'b1 && cyc < 100) begin
            cyc++;
            step();
        end
        total++;
        if (cyc !== 5 || bus.lo !== 32'd12 || bus.hi !== 32'd0) begin
            bad++;
            $display("FAIL b2b_second cycles=%0d hi=%h lo=%h expected 5/00000000/0000000c", cyc, bus.hi, bus.lo);
        end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.op     = 3'd0;
        bus.rs_val = 32'd0;
        bus.rt_val = 32'd0;
        test_reset();
        test_mult();
        test_div();
        test_div_edge();
        test_ignored_start();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
